axis_spm_offset_mover: RTL and testbench

AXIS_SPM_OFFSET_MOVER -- requirements
Module: axis_spm_offset_mover

---
 rtl/spm_ctrl_pkg.sv | 14 +
 rtl/spm_axis_stepper.sv | 28 ++
 rtl/axis_spm_offset_mover.sv | 117 +++++++++++
 tb/tb_axis_spm_offset_mover.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spm_ctrl_pkg.sv
// Shared definitions for the scan-offset mover: FSM state encoding and default widths.
package spm_ctrl_pkg;

    localparam int POS_WIDTH_DEF = 32;
    localparam int DIV_WIDTH_DEF = 16;
    localparam int NUM_AXES      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/spm_axis_stepper.sv
// One axis of the mover: next position after a tick, clamped so it never
// overshoots the target. Pure combinational.
module spm_axis_stepper #(
    parameter int W = 32
) (
    input  logic [W-1:0] pos,
    input  logic [W-1:0] target,
    input  logic [W-1:0] step,
    output logic [W-1:0] next
);

    logic [W:0] pos_ext;
    logic [W:0] tgt_ext;
    logic [W:0] diff;
    logic [W:0] mag;

    // One extra bit keeps the signed distance exact across the full range.
    assign pos_ext = {pos[W-1], pos};
    assign tgt_ext = {target[W-1], target};
    assign diff    = tgt_ext - pos_ext;
    assign mag     = diff[W] ? ('0 - diff) : diff;

    // When the step covers the remaining distance, land exactly on the target;
    // otherwise the result lies strictly between pos and target, so no wrap.
    assign next = ({1'b0, step} >= mag) ? target
                : (diff[W] ? (pos - step) : (pos + step));

endmodule

// File: rtl/axis_spm_offset_mover.sv
// Moves the three registered scan offsets toward latched targets in bounded
// steps, one step per divided tick, with abort and completion pulses.
module axis_spm_offset_mover
    import spm_ctrl_pkg::*;
#(
    parameter int POS_WIDTH = POS_WIDTH_DEF,
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 a_clk,
    input  logic                 a_rst,
    input  logic [POS_WIDTH-1:0] cfg_x0_target,
    input  logic [POS_WIDTH-1:0] cfg_y0_target,
    input  logic [POS_WIDTH-1:0] cfg_z0_target,
    input  logic [POS_WIDTH-1:0] cfg_step,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 start,
    input  logic                 abort,
    output logic [POS_WIDTH-1:0] x0,
    output logic [POS_WIDTH-1:0] y0,
    output logic [POS_WIDTH-1:0] z0,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    state_t               state_reg;
    logic [POS_WIDTH-1:0] pos_reg    [NUM_AXES];
    logic [POS_WIDTH-1:0] target_reg [NUM_AXES];
    logic [POS_WIDTH-1:0] pos_next   [NUM_AXES];
    logic [POS_WIDTH-1:0] cfg_target [NUM_AXES];
    logic [POS_WIDTH-1:0] step_reg;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] tick_cnt_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 aborted_reg;
    logic [NUM_AXES-1:0]  axis_at;
    logic                 all_at;

    assign cfg_target[0] = cfg_x0_target;
    assign cfg_target[1] = cfg_y0_target;
    assign cfg_target[2] = cfg_z0_target;

    generate
        for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
            spm_axis_stepper #(.W(POS_WIDTH)) u_stepper (
                .pos    (pos_reg[gi]),
                .target (target_reg[gi]),
                .step   (step_reg),
                .next   (pos_next[gi])
            );
            assign axis_at[gi] = (pos_reg[gi] == target_reg[gi]);
        end
    endgenerate

    assign all_at = &axis_at;

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state_reg    <= ST_IDLE;
            step_reg     <= '0;
            div_reg      <= '0;
            tick_cnt_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            aborted_reg  <= 1'b0;
            for (int i = 0; i < NUM_AXES; i++) begin
                pos_reg[i]    <= '0;
                target_reg[i] <= '0;
            end
        end else begin
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start && !abort) begin
                        for (int i = 0; i < NUM_AXES; i++)
                            target_reg[i] <= cfg_target[i];
                        step_reg     <= cfg_step;
                        div_reg      <= cfg_div;
                        tick_cnt_reg <= cfg_div;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    // A zero step with distance left could never finish.
                    if (abort || (step_reg == '0 && !all_at)) begin
                        busy_reg    <= 1'b0;
                        aborted_reg <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else if (all_at) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (tick_cnt_reg == '0) begin
                        tick_cnt_reg <= div_reg;
                        for (int i = 0; i < NUM_AXES; i++)
                            pos_reg[i] <= pos_next[i];
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg - DIV_WIDTH'(1);
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign x0      = pos_reg[0];
    assign y0      = pos_reg[1];
    assign z0      = pos_reg[2];
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign aborted = aborted_reg;

endmodule

// File: tb/tb_axis_spm_offset_mover.sv
// Directed bench for axis_spm_offset_mover with hand-computed expectations.
module tb_axis_spm_offset_mover;

    localparam int PW = 32;
    localparam int DW = 16;

    logic          a_clk = 1'b0;
    logic          a_rst = 1'b1;
    logic [PW-1:0] cfg_x0_target = '0;
    logic [PW-1:0] cfg_y0_target = '0;
    logic [PW-1:0] cfg_z0_target = '0;
    logic [PW-1:0] cfg_step = '0;
    logic [DW-1:0] cfg_div = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] x0, y0, z0;
    logic          busy, done, aborted;

    int err_cnt = 0;
    int chk_cnt = 0;

    axis_spm_offset_mover #(.POS_WIDTH(PW), .DIV_WIDTH(DW)) dut (
        .a_clk         (a_clk),
        .a_rst         (a_rst),
        .cfg_x0_target (cfg_x0_target),
        .cfg_y0_target (cfg_y0_target),
        .cfg_z0_target (cfg_z0_target),
        .cfg_step      (cfg_step),
        .cfg_div       (cfg_div),
        .start         (start),
        .abort         (abort),
        .x0            (x0),
        .y0            (y0),
        .z0            (z0),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    always #5 a_clk = ~a_clk;

    task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge a_clk);
        #1;
    endtask

    task automatic setup(input logic [PW-1:0] tx, input logic [PW-1:0] ty, input logic [PW-1:0] tz,
                         input logic [PW-1:0] st, input logic [DW-1:0] dv);
        cfg_x0_target = tx;
        cfg_y0_target = ty;
        cfg_z0_target = tz;
        cfg_step      = st;
        cfg_div       = dv;
    endtask

    task automatic pulse_start();
        $display("start: tgt=(%0h,%0h,%0h) step=%0h div=%0d", cfg_x0_target, cfg_y0_target,
                 cfg_z0_target, cfg_step, cfg_div);
        start = 1'b1;
        clk1();
        start = 1'b0;
    endtask

    task automatic do_reset();
        a_rst = 1'b1;
        clk1();
        a_rst = 1'b0;
        $display("reset");
    endtask

    initial begin
        logic [PW-1:0] exp_x [5];
        logic [PW-1:0] ye;

        clk1();
        clk1();
        chk("rst_x0", x0, 0);
        chk("rst_y0", y0, 0);
        chk("rst_z0", z0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        a_rst = 1'b0;

        // 0 -> 100, step 30, div 0; cfg changes and a second start mid-move are ignored
        exp_x = '{32'd0, 32'd30, 32'd60, 32'd90, 32'd100};
        setup(100, 0, 0, 30, 0);
        pulse_start();
        setup(999, 7, 7, 1, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("seq_x0_%0d", k), x0, exp_x[k]);
            chk($sformatf("seq_busy_%0d", k), busy, 1);
            chk($sformatf("seq_done_%0d", k), done, 0);
            start = (k == 1);
            clk1();
        end
        start = 1'b0;
        chk("seq_done_pulse", done, 1);
        chk("seq_busy_drop", busy, 0);
        chk("seq_x0_final", x0, 100);
        chk("seq_y0_final", y0, 0);
        clk1();
        chk("seq_done_once", done, 0);
        $display("move 0->100 complete");

        // start+abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        clk1();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_idle_busy", busy, 0);
        clk1();
        chk("sa_idle_busy2", busy, 0);
        chk("sa_idle_x0", x0, 100);
        chk("sa_idle_aborted", aborted, 0);

        // full-range move without wrap
        setup(32'h7FFF_FFF0, 0, 0, 32'hFFFF_FFFF, 0);
        pulse_start();
        clk1();
        chk("big_x0_pos", x0, 32'h7FFF_FFF0);
        clk1();
        chk("big_done1", done, 1);
        clk1();
        setup(32'h8000_0000, 0, 0, 32'hFFFF_FFFF, 0);
        pulse_start();
        clk1();
        chk("big_x0_neg", x0, 32'h8000_0000);
        clk1();
        chk("big_done2", done, 1);
        clk1();

        // three axes, step 10, div 3
        do_reset();
        setup(50, -20, 0, 10, 3);
        pulse_start();
        repeat (3) clk1();
        chk("div_x0_pre", x0, 0);
        for (int k = 1; k <= 5; k++) begin
            repeat ((k == 1) ? 1 : 4) clk1();
            ye = (k >= 2) ? -20 : -10 * k;
            chk($sformatf("div_x0_t%0d", k), x0, PW'(10 * k));
            chk($sformatf("div_y0_t%0d", k), y0, ye);
            chk($sformatf("div_z0_t%0d", k), z0, 0);
        end
        chk("div_busy_end", busy, 1);
        chk("div_done_early", done, 0);
        clk1();
        chk("div_done", done, 1);
        clk1();

        // abort in cycle 7 of 0 -> 1000
        do_reset();
        setup(1000, 0, 0, 100, 0);
        pulse_start();
        repeat (6) clk1();
        chk("abt_x0_before", x0, 600);
        abort = 1'b1;
        clk1();
        abort = 1'b0;
        chk("abt_x0_frozen", x0, 600);
        chk("abt_pulse", aborted, 1);
        chk("abt_busy", busy, 0);
        chk("abt_done", done, 0);
        clk1();
        chk("abt_pulse_once", aborted, 0);
        chk("abt_no_done", done, 0);
        chk("abt_x0_held", x0, 600);

        // step 0 with distance left aborts at once
        setup(5, 0, 0, 0, 0);
        pulse_start();
        clk1();
        chk("step0_aborted", aborted, 1);
        chk("step0_busy", busy, 0);
        chk("step0_x0", x0, 600);
        clk1();

        // reset mid-move, then a zero-distance move
        setup(1000, 0, 0, 100, 0);
        pulse_start();
        clk1();
        chk("rstmv_x0_moving", x0, 700);
        a_rst = 1'b1;
        start = 1'b1;
        clk1();
        a_rst = 1'b0;
        start = 1'b0;
        chk("rstmv_x0", x0, 0);
        chk("rstmv_busy", busy, 0);
        chk("rstmv_done", done, 0);
        clk1();
        chk("rstmv_start_blocked", busy, 0);
        setup(0, 0, 0, 1, 0);
        pulse_start();
        chk("zero_busy", busy, 1);
        chk("zero_done_early", done, 0);
        clk1();
        chk("zero_done", done, 1);
        chk("zero_x0", x0, 0);

        // abort while in DONE is ignored
        abort = 1'b1;
        clk1();
        abort = 1'b0;
        chk("done_abort_ignored", aborted, 0);
        chk("done_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
